// File: rtl/pwm4_gen_if.sv
// pwm4_gen_if: PIO-facing bundle for the four-channel PWM generator.
// The master drives settings, and the slave returns the PWM and wrap outputs.
interface pwm4_gen_if #(
  parameter int WIDTH = 28,
  parameter int CH    = 4
);
  logic [CH*WIDTH-1:0] period_in;
  logic [CH*WIDTH-1:0] decode_in;
  logic [CH-1:0]       pwm_out;
  logic [CH-1:0]       wrap_out;

  modport master (
    output period_in,
    output decode_in,
    input  pwm_out,
    input  wrap_out
  );

  modport slave (
    input  period_in,
    input  decode_in,
    output pwm_out,
    output wrap_out
  );
endinterface

// File: rtl/pwm4_gen.sv
// pwm4_gen: four independent PWM channels with period-boundary shadow loads.
// Outputs are registered from next-state values, so there is no comb path to pins.
module pwm4_chan #(
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] decode,
  output logic             pwm,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] p_act;
  logic [WIDTH-1:0] d_act;
  logic [WIDTH-1:0] cnt_n;
  logic [WIDTH-1:0] p_n;
  logic [WIDTH-1:0] d_n;
  logic [WIDTH-1:0] last;
  logic [WIDTH-1:0] last_n;
  logic             run;
  logic             run_n;
  logic             ld;
  logic             pwm_n;
  logic             wrap_n;

  // Load on a period boundary or while disabled; otherwise count up.
  always_comb begin
    run    = (p_act != '0);
    last   = run ? (p_act - ONE) : '0;
    ld     = !run || (cnt == last);
    cnt_n  = cnt + ONE;
    p_n    = p_act;
    d_n    = d_act;
    if (ld) begin
      cnt_n = '0;
      p_n   = period;
      d_n   = decode;
    end
    run_n  = (p_n != '0);
    last_n = run_n ? (p_n - ONE) : '0;
    pwm_n  = run_n && (cnt_n < d_n);
    wrap_n = run_n && (cnt_n == last_n);
  end

  // Counter, shadows and output flops share one async-cleared register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      p_act <= '0;
      d_act <= '0;
      pwm   <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      p_act <= p_n;
      d_act <= d_n;
      pwm   <= pwm_n;
      wrap  <= wrap_n;
    end
  end
endmodule

module pwm4_gen #(
  parameter int WIDTH = 28,
  parameter int CH    = 4
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  pwm4_gen_if.slave  bus
);
  logic [CH-1:0] pwm_v;
  logic [CH-1:0] wrap_v;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    pwm4_chan #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .period(bus.period_in[g*WIDTH +: WIDTH]),
      .decode(bus.decode_in[g*WIDTH +: WIDTH]),
      .pwm   (pwm_v[g]),
      .wrap  (wrap_v[g])
    );
  end

  assign bus.pwm_out  = pwm_v;
  assign bus.wrap_out = wrap_v;
endmodule

// File: doc/pwm4_gen.md
# pwm4_gen

Four-channel PWM generator that sits directly downstream of the Nios II system's period and decode PIO exports. Each channel takes a 28-bit period word and a 28-bit high-time word from the processor. It produces a glitch-free PWM output plus an end-of-period strobe. New settings take effect only at a period boundary, so the processor can rewrite a channel at any time without causing runt pulses.

## Interface

- `WIDTH`, 28: bit width of period, high-time and counter.
- `CH`, 4: number of channels.

- `clk_clk`  in  1  system clock; same domain as the PIO exports.
- `reset_reset_n`  in  1  asynchronous active-low reset.
- `period_in`  in  CH*WIDTH  channel n period at bits [n*WIDTH +: WIDTH]. period1 export maps to channel 0, period4 to channel 3.
- `decode_in`  in  CH*WIDTH  channel n high-time, same packing. decode1 export maps to channel 0.
- `pwm_out`  out  CH  PWM output per channel; registered.
- `wrap_out`  out  CH  one-cycle strobe on the last cycle of each period; registered.

## Operation

- Per-channel state:
  - `cnt` (WIDTH): counter.
  - `p_act` (WIDTH): active period shadow.
  - `d_act` (WIDTH): active high-time shadow.
- Inputs are consumed only through the shadows. Input changes outside a load edge have no effect.
- Load condition, evaluated each edge: `p_act == 0` OR `cnt == p_act - 1`.
  - On a load edge:
    - `p_act <= period_in[n]`
    - `d_act <= decode_in[n]`
    - `cnt <= 0`
  - Otherwise `cnt <= cnt + 1`.
- `p_act == 0` means the channel is disabled:
  - counter held at 0;
  - `pwm_out` low, `wrap_out` low;
  - shadows reload every cycle, so a nonzero period written while disabled starts on the next edge.
- Output rule: `pwm_out` flop always equals `(cnt < d_act) && (p_act != 0)`, computed on the register state it is aligned with. It is computed from next-state values, so there is no combinational path to the pin.
- Duty boundary cases:
  - `d_act == 0`: constant low.
  - `d_act >= p_act`: constant high (100%), with no low cycle at wrap.
- `wrap_out` flop equals `(cnt == p_act - 1) && (p_act != 0)` on its aligned state.
- Period 1 case: `p_act == 1` gives `wrap_out` high continuously. `pwm_out` equals `(d_act != 0)`.
- Arithmetic:
  - Unsigned compares.
  - `p_act - 1` is evaluated only when `p_act != 0`.
  - `cnt` never exceeds `p_act - 1`, so there is no overflow at `p_act = 2^WIDTH - 1`.
- Channels are fully independent, with no shared state.

## Timing

- Reset (asynchronous assert, synchronous release on the first edge):
  - `cnt = 0`, `p_act = 0`, `d_act = 0`
  - `pwm_out = 0`, `wrap_out = 0`
- From the disabled state, writing period P ≥ 1:
  - the next edge loads it;
  - `pwm_out` reflects `cnt = 0` in the following cycle (1-cycle latency).
- With `p_act = P` running, output pattern per period:
  - `pwm_out` high for cycles `cnt = 0 .. min(D,P) - 1`, low for the rest;
  - exactly P cycles per period.
- A new `decode_in` or `period_in` value written mid-period takes effect at the first cycle after the next `wrap_out` cycle.
- A value written in the same cycle as `wrap_out` is captured at that load edge.
- Writing period 0 while running: the channel finishes the current period, then disables.
- Reset asserted mid-period: outputs go low immediately (asynchronously), and all shadows are cleared.

## Test plan

- Reset: hold `reset_reset_n` low with arbitrary inputs. Then `pwm_out = 4'b0000` and `wrap_out = 4'b0000`, and both stay 0 while all periods are 0.
- Basic PWM: ch0 P=10, D=3 from disabled.
  - After a 1-cycle latency, `pwm_out[0]` repeats 3 high / 7 low.
  - `wrap_out[0]` pulses on every 10th cycle, coinciding with the last low cycle.
- Mid-period update: ch1 P=8, D=2 running; write D=6 at `cnt = 3`.
  - The current period stays 2 high.
  - The next period is 6 high / 2 low.
  - A write coinciding with `wrap_out[1]` is applied immediately.
- Duty extremes:
  - ch2 P=5 with D=0: constant low, `wrap_out` every 5 cycles.
  - D=5 and D=100: constant high, no low glitch at wrap.
- Period 1 and disable:
  - ch3 P=1, D=1: `pwm_out[3]` and `wrap_out[3]` constantly high.
  - Then P=0: low after the current one-cycle period; re-enabling with P=4, D=2 starts on the next edge.
- Reset mid-operation: all channels running; assert reset at random `cnt`. Outputs drop in the same cycle, and after release the channels reload from the inputs starting at `cnt = 0`.
